// File: rtl/nibble_add_seq_ctrl.sv
// nibble_add_seq_ctrl: adds two W-bit operands (W = 4*NIBBLES) by stepping one
// 4-bit ripple-carry slice through the operands, least-significant nibble first.
// The carry between nibbles lives in a register, so the critical path is one
// 4-bit ripple chain regardless of operand width.

// NibbleRippleAdder: 4-bit full-adder chain exposing every stage carry.
module NibbleRippleAdder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] sum_o,
    output logic [3:0] carry_o
);

    logic rippleC;

    // Ripple the carry through four full adders, recording each stage carry.
    always_comb begin
        rippleC = c_i;
        sum_o   = 4'b0000;
        carry_o = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            sum_o[k]   = a_i[k] ^ b_i[k] ^ rippleC;
            rippleC    = (a_i[k] & b_i[k]) | (rippleC & (a_i[k] ^ b_i[k]));
            carry_o[k] = rippleC;
        end
    end

endmodule

module nibble_add_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [4*NIBBLES-1:0]   a_i,
    input  logic [4*NIBBLES-1:0]   b_i,
    input  logic                   c_in_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [4*NIBBLES-1:0]   sum_o,
    output logic                   c_out_o,
    output logic                   ovf_o
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            c_out_q, c_out_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [3:0]      sliceSum;
    logic [3:0]      sliceCarry;
    logic [W+3:0]    sumWide;
    logic            lastNibble;
    logic            unusedCarries;

    // Only stage-2 and stage-3 carries matter to the sequencer.
    assign unusedCarries = ^sliceCarry[1:0];

    NibbleRippleAdder u_slice (
        .a_i     (a_q[3:0]),
        .b_i     (b_q[3:0]),
        .c_i     (carry_q),
        .sum_o   (sliceSum),
        .carry_o (sliceCarry)
    );

    // New nibble enters at the top; after NIBBLES shifts the sum is right-aligned.
    assign sumWide    = {sliceSum, sum_q};
    assign lastNibble = (cnt_q == CW'(NIBBLES - 1));

    // Next-state and datapath update: latch on accept, step one nibble per RUN cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = c_in_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = sumWide[W+3:4];
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = sliceCarry[3];
                cnt_d   = cnt_q + CW'(1);
                if (lastNibble) begin
                    c_out_d = sliceCarry[3];
                    ovf_d   = sliceCarry[2] ^ sliceCarry[3];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous clear that discards any in-flight add.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o  = (state_q == RUN);
    assign done_o  = (state_q == DONE);
    assign sum_o   = sum_q;
    assign c_out_o = c_out_q;
    assign ovf_o   = ovf_q;

endmodule
